spi_sram_slave: RTL and testbench
=================================

SPI_SRAM_SLAVE -- requirements
Module: spi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 17, SHALL set the memory address width (128 KB array).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of input synchronizer flops on spi_cs_n, spi_sclk, spi_mosi and spi_hold_n.
REQ-003 clk  input  1  SHALL be the single system clock; every flop SHALL be clocked on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 spi_cs_n  input  1  SHALL be the SPI chip select, active low.
REQ-006 spi_sclk  input  1  SHALL be the SPI clock (mode 0).
REQ-007 spi_mosi  input  1  SHALL be serial data from the initiator.
REQ-008 spi_hold_n  input  1  SHALL be the HOLD input, active low.
REQ-009 spi_miso  output  1  SHALL be serial data to the initiator.
REQ-010 spi_miso_oe  output  1  SHALL be the MISO output enable for the top-level tristate.
REQ-011 mem_addr  output  ADDR_W  SHALL be the memory byte address.
REQ-012 mem_wdata  output  8  SHALL be the memory write data.
REQ-013 mem_we  output  1  SHALL be a one-clk write strobe.
REQ-014 mem_re  output  1  SHALL be a one-clk read strobe; mem_rdata is valid exactly 1 clk later.
REQ-015 mem_rdata  input  8  SHALL be the memory read data.
REQ-016 mode  output  2  SHALL be the current mode register: 00 byte, 10 page, 01 sequential.

Function
REQ-017 SPI inputs SHALL pass through SYNC_STAGES flops; SCLK edges SHALL be detected in the clk domain; clk SHALL be at least 8x SCLK.
REQ-018 MOSI SHALL be sampled on detected SCLK rise; MISO SHALL change on detected SCLK fall; MSB first.
REQ-019 FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDMR, WRMR, IGNORE.
REQ-020 IDLE->CMD on synced spi_cs_n falling; CMD collects 8 bits.
REQ-021 Command decode at 8th bit: 0x03->ADDR (read), 0x02->ADDR (write), 0x05->RDMR, 0x01->WRMR, anything else->IGNORE.
REQ-022 ADDR SHALL collect 24 bits; the upper 24-ADDR_W bits SHALL be discarded.
REQ-023 Read: mem_re SHALL pulse 1 clk after the 24th address bit is sampled; the byte SHALL be loaded into the shifter and its bit 7 driven on the next SCLK fall.
REQ-024 Read: the next byte SHALL be prefetched (mem_re) 1 clk after the 8th rising edge of each byte with the incremented address.
REQ-025 Write: after each 8th data bit, mem_we SHALL pulse 1 clk with mem_wdata = received byte at mem_addr; address then increments.
REQ-026 Increment: sequential wraps 0x1FFFF->0x00000; page wraps within the 32-byte page (addr[4:0] only); byte mode performs one access, then moves to IGNORE.
REQ-027 RDMR SHALL shift {mode,6'b0} repeatedly; WRMR SHALL set mode = byte[7:6] on the 8th bit, then move to IGNORE.
REQ-028 spi_miso_oe SHALL be 1 only in RD_DATA and RDMR with CS active; spi_miso SHALL be 0 when not enabled.
REQ-029 Synced spi_cs_n rising in any state SHALL return the FSM to IDLE; a partial write byte SHALL be discarded (no mem_we) and oe SHALL drop within SYNC_STAGES+1 clk.
REQ-030 mem_we and mem_re SHALL never assert in the same clk.

Reset
REQ-031 While rst_n=0: state=IDLE, spi_miso=0, spi_miso_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, mode=01, synchronizers reset to idle levels (cs_n=1, sclk=0, hold_n=1).
REQ-032 Reset asserted mid-transaction SHALL abort it without any memory strobe; after release the block SHALL wait for a fresh CS falling edge.

Configuration
REQ-033 Macro SPI_HOLD_EN defined: while synced spi_hold_n=0 with CS active, SCLK edges SHALL be ignored, spi_miso_oe=0, and all state SHALL be held; the transfer SHALL resume bit-exact after spi_hold_n returns to 1.
REQ-034 SPI_HOLD_EN undefined: spi_hold_n SHALL be ignored; the port SHALL remain present.

Verification
REQ-035 Write 0x02, addr 0x000010, data 0xA5,0x5A -> mem_we twice: (0x00010,0xA5),(0x00011,0x5A).
REQ-036 Read 0x03, addr 0x01FFFF, mem returns 0x3C then 0xC3 -> MISO 0x3C,0xC3; second mem_re at 0x00000 (sequential wrap).
REQ-037 WRMR 0x01 data 0x80, then write 0x02 addr 0x00001F data 0x11,0x22 -> mode=10; writes at 0x0001F, 0x00000.
REQ-038 WRMR data 0x00, then read at 0x000005 clocking 16 bits -> one mem_re only; second byte not driven (oe=0).
REQ-039 CS raised after 5 data bits of a write -> no mem_we; state IDLE; next command decodes normally.
REQ-040 With SPI_HOLD_EN, hold_n low for 4 SCLK periods mid-read of byte 0x96 -> oe=0 during hold; MISO reads 0x96 intact after release.

Source files
------------

// File: rtl/spi_sram_slave.sv
// spi_sram_slave
//   SPI mode-0 slave front end for a byte-wide SRAM (23LC1024-style command
//   set: READ 0x03, WRITE 0x02, RDMR 0x05, WRMR 0x01). The SPI pins are
//   oversampled in the clk domain. clk must run at least 8x SCLK.
//
//   Optional build macro: SPI_HOLD_EN. When it is defined, a low spi_hold_n
//   with CS active freezes the transfer. When it is undefined, spi_hold_n is
//   ignored.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_cs_n, spi_sclk  SPI chip select (active low), SPI clock
//   spi_mosi, spi_miso  serial data in / out (MSB first)
//   spi_hold_n          HOLD input (active low)
//   spi_miso_oe         MISO output enable for the pad tristate
//   mem_addr            memory byte address
//   mem_wdata, mem_we   write data and one-clk write strobe
//   mem_re, mem_rdata   one-clk read strobe; data returns one clk later
//   mode                mode register: 00 byte, 10 page, 01 sequential
module spi_sram_slave #(
  parameter int ADDR_W      = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_hold_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        mode
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_WR_DATA = 3'd4;
  localparam logic [2:0] ST_RDMR    = 3'd5;
  localparam logic [2:0] ST_WRMR    = 3'd6;
  localparam logic [2:0] ST_IGNORE  = 3'd7;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync, hold_sync;
  logic                   cs_q, sclk_q;
  logic                   cs_s, sclk_s, mosi_s, hold_s, hold_act;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [2:0]             state;
  logic [4:0]             bit_cnt;
  logic [7:0]             rx_sr, rx_next, tx_sr;
  logic                   is_read, last_bit, ld_vld_p1, miso_q;

  // Sequential wraps at the top of the array; page wraps inside the
  // 32-byte page; byte mode never reaches a second access.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        m);
    if (m == MODE_PAGE) next_addr = {a[ADDR_W-1:5], a[4:0] + 5'd1};
    else                next_addr = a + ADDR_W'(1);
  endfunction

  // Input synchronizers (reset to the idle pin levels) and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      hold_sync <= '1;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
    end else begin
      cs_sync   <= (cs_sync << 1)   | SYNC_STAGES'(spi_cs_n);
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(spi_sclk);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
      hold_sync <= (hold_sync << 1) | SYNC_STAGES'(spi_hold_n);
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign hold_s = hold_sync[SYNC_STAGES-1];

`ifdef SPI_HOLD_EN
  assign hold_act = ~hold_s & ~cs_s;
`else
  assign hold_act = 1'b0 & ~hold_s;
`endif

  // While HOLD is active, SCLK edges are swallowed, so every register keeps
  // its value and the transfer resumes exactly where it stopped.
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = ~sclk_q & sclk_s & ~cs_s & ~hold_act;
  assign sclk_fall = sclk_q & ~sclk_s & ~cs_s & ~hold_act;
  assign rx_next   = {rx_sr[6:0], mosi_s};
  assign last_bit  = (bit_cnt == 5'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      is_read     <= 1'b0;
      ld_vld_p1   <= 1'b0;
      miso_q      <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mode        <= MODE_SEQ;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      ld_vld_p1 <= mem_re;
      // Address advances in the clk after a write strobe.
      if (mem_we) mem_addr <= next_addr(mem_addr, mode);

      if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                case (rx_next)
                  8'h03:   begin state <= ST_ADDR; is_read <= 1'b1; end
                  8'h02:   begin state <= ST_ADDR; is_read <= 1'b0; end
                  8'h05:   begin state <= ST_RDMR; tx_sr <= {mode, 6'b0}; end
                  8'h01:   state <= ST_WRMR;
                  default: state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            // Shifting into an ADDR_W-wide register drops the unused upper bits.
            if (sclk_rise) begin
              mem_addr <= {mem_addr[ADDR_W-2:0], mosi_s};
              bit_cnt  <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (is_read) begin
                  state  <= ST_RD_DATA;
                  mem_re <= 1'b1;
                end else begin
                  state  <= ST_WR_DATA;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (sclk_fall) begin
              miso_q <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                if (mode == MODE_BYTE) begin
                  state <= ST_IGNORE;
                end else begin
                  mem_addr <= next_addr(mem_addr, mode);
                  mem_re   <= 1'b1;
                end
              end
            end
          end
          ST_WR_DATA: begin
            if (sclk_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                bit_cnt   <= '0;
                mem_wdata <= rx_next;
                mem_we    <= 1'b1;
                if (mode == MODE_BYTE) state <= ST_IGNORE;
              end
            end
          end
          ST_RDMR: begin
            if (sclk_fall) begin
              miso_q <= tx_sr[7];
              tx_sr  <= {tx_sr[6:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                tx_sr   <= {mode, 6'b0};
              end
            end
          end
          ST_WRMR: begin
            if (sclk_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 5'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                mode    <= rx_next[7:6];
                state   <= ST_IGNORE;
              end
            end
          end
          ST_IGNORE: ;
          default: state <= ST_IDLE;
        endcase
      end

      // Read data (one clk after mem_re) wins over any shift in the same clk.
      if (ld_vld_p1 && state == ST_RD_DATA) tx_sr <= mem_rdata;

      spi_miso_oe <= (state == ST_RD_DATA || state == ST_RDMR) &&
                     !cs_s && !hold_act && !cs_rise;
    end
  end

  assign spi_miso = miso_q & spi_miso_oe;

endmodule

// File: tb/tb_spi_sram_slave.sv
// tb_spi_sram_slave
//   Drives spi_sram_slave as an SPI mode-0 initiator. A behavioural SRAM
//   answers mem_re one clk later. Expected memory strobes are queued before
//   each transaction and checked as the DUT issues them.
module tb_spi_sram_slave;

  localparam int HALF = 8;   // clk cycles per SCLK half period
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs_n, spi_sclk, spi_mosi, spi_hold_n;
  logic        spi_miso, spi_miso_oe;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  bit [7:0] mem [0:131071];

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_we_q[$];
  logic [16:0] exp_re_q[$];

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    bit          has_addr;
    logic [23:0] addr;
    int          nbytes;
    logic [15:0] txd;
    logic [15:0] rxd;
    logic [1:0]  oe;
    int          nwe;
    logic [16:0] we_a0, we_a1;
    logic [7:0]  we_d0, we_d1;
    int          nre;
    logic [16:0] re_a0, re_a1, re_a2;
    logic [1:0]  mode;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  spi_sram_slave #(.ADDR_W(17), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_hold_n (spi_hold_n),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mode       (mode)
  );

  // Behavioural SRAM
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Strobe scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        if (exp_we_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_we actual addr=%05h data=%02h required no write", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = exp_we_q.pop_front();
          if (mem_addr !== e.a || mem_wdata !== e.d) begin
            failures++;
            $display("FAIL we actual addr=%05h data=%02h required addr=%05h data=%02h", mem_addr, mem_wdata, e.a, e.d);
          end
        end
      end
      if (mem_re) begin
        checks++;
        if (exp_re_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_re actual addr=%05h required no read", mem_addr);
        end else begin
          logic [16:0] ea;
          ea = exp_re_q.pop_front();
          if (mem_addr !== ea) begin
            failures++;
            $display("FAIL re actual addr=%05h required addr=%05h", mem_addr, ea);
          end
        end
      end
      if (mem_we && mem_re) begin
        checks++;
        failures++;
        $display("FAIL we_re_overlap actual both=1 required at most one");
      end
      if (!spi_miso_oe) begin
        checks++;
        if (spi_miso !== 1'b0) begin
          failures++;
          $display("FAIL miso_idle actual=%b required=0", spi_miso);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic mi, output logic oe);
    spi_mosi = b;
    wait_clks(HALF);
    mi = spi_miso;
    oe = spi_miso_oe;
    spi_sclk = 1'b1;
    wait_clks(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe0);
    logic mi, oe;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], mi, oe);
      rx[i] = mi;
      if (i == 7) oe0 = oe;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    spi_cs_n = 1'b1;
    wait_clks(SYNC + 6);
  endtask

  task automatic run_vec(input vec_t t);
    logic [7:0] rx, tx, erx;
    logic       oe, eoe;
    if (t.nwe >= 1) exp_we_q.push_back({t.we_a0, t.we_d0});
    if (t.nwe >= 2) exp_we_q.push_back({t.we_a1, t.we_d1});
    if (t.nre >= 1) begin exp_re_q.push_back(t.re_a0); mem[t.re_a0] = t.rxd[15:8]; end
    if (t.nre >= 2) begin
      exp_re_q.push_back(t.re_a1);
      if (t.nbytes >= 2) mem[t.re_a1] = t.rxd[7:0];
    end
    if (t.nre >= 3) exp_re_q.push_back(t.re_a2);
    cs_low();
    xfer_byte(t.cmd, rx, oe);
    if (t.has_addr)
      for (int k = 2; k >= 0; k--) xfer_byte(t.addr[8*k +: 8], rx, oe);
    for (int b = 0; b < t.nbytes; b++) begin
      tx  = (b == 0) ? t.txd[15:8] : t.txd[7:0];
      erx = (b == 0) ? t.rxd[15:8] : t.rxd[7:0];
      eoe = (b == 0) ? t.oe[1] : t.oe[0];
      xfer_byte(tx, rx, oe);
      chk({t.name, "_miso"}, 32'(rx), 32'(erx));
      chk({t.name, "_oe"}, 32'(oe), 32'(eoe));
    end
    cs_high();
    chk({t.name, "_mode"}, 32'(mode), 32'(t.mode));
    chk({t.name, "_oe_after_cs"}, 32'(spi_miso_oe), 32'h0);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe, mi;
    spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_hold_n = 1'b1;
    rst_n = 1'b0;
    wait_clks(3);
    chk("rst_miso", 32'(spi_miso), 32'h0);
    chk("rst_oe", 32'(spi_miso_oe), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_re", 32'(mem_re), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mode", 32'(mode), 32'h1);
    rst_n = 1'b1;
    wait_clks(4);

    //           name        cmd    addr? addr        n  txd       rxd       oe     nwe we_a0      we_a1      d0     d1     nre re_a0      re_a1      re_a2      mode
    vecs[0]  = '{"wr_seq",   8'h02, 1'b1, 24'h000010, 2, 16'hA55A, 16'h0000, 2'b00, 2, 17'h00010, 17'h00011, 8'hA5, 8'h5A, 0, 17'h0,     17'h0,     17'h0,     2'b01};
    vecs[1]  = '{"rd_wrap",  8'h03, 1'b1, 24'h01FFFF, 2, 16'h0000, 16'h3CC3, 2'b11, 0, 17'h0,     17'h0,     8'h00, 8'h00, 3, 17'h1FFFF, 17'h00000, 17'h00001, 2'b01};
    vecs[2]  = '{"wrmr_pg",  8'h01, 1'b0, 24'h0,      1, 16'h8000, 16'h0000, 2'b00, 0, 17'h0,     17'h0,     8'h00, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b10};
    vecs[3]  = '{"wr_page",  8'h02, 1'b1, 24'h00001F, 2, 16'h1122, 16'h0000, 2'b00, 2, 17'h0001F, 17'h00000, 8'h11, 8'h22, 0, 17'h0,     17'h0,     17'h0,     2'b10};
    vecs[4]  = '{"rdmr_pg",  8'h05, 1'b0, 24'h0,      2, 16'h0000, 16'h8080, 2'b11, 0, 17'h0,     17'h0,     8'h00, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b10};
    vecs[5]  = '{"wrmr_byte",8'h01, 1'b0, 24'h0,      1, 16'h0000, 16'h0000, 2'b00, 0, 17'h0,     17'h0,     8'h00, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b00};
    vecs[6]  = '{"rd_byte",  8'h03, 1'b1, 24'h000005, 2, 16'h0000, 16'h6900, 2'b10, 0, 17'h0,     17'h0,     8'h00, 8'h00, 1, 17'h00005, 17'h0,     17'h0,     2'b00};
    vecs[7]  = '{"wr_byte",  8'h02, 1'b1, 24'h000100, 2, 16'h7788, 16'h0000, 2'b00, 1, 17'h00100, 17'h0,     8'h77, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b00};
    vecs[8]  = '{"wrmr_seq", 8'h01, 1'b0, 24'h0,      1, 16'h4000, 16'h0000, 2'b00, 0, 17'h0,     17'h0,     8'h00, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b01};
    vecs[9]  = '{"bad_cmd",  8'hFF, 1'b0, 24'h0,      2, 16'h1234, 16'h0000, 2'b00, 0, 17'h0,     17'h0,     8'h00, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b01};
    vecs[10] = '{"wrmr_pg2", 8'h01, 1'b0, 24'h0,      1, 16'h8000, 16'h0000, 2'b00, 0, 17'h0,     17'h0,     8'h00, 8'h00, 0, 17'h0,     17'h0,     17'h0,     2'b10};
    vecs[11] = '{"rd_page",  8'h03, 1'b1, 24'hFE013F, 1, 16'h0000, 16'hE100, 2'b10, 0, 17'h0,     17'h0,     8'h00, 8'h00, 2, 17'h0013F, 17'h00120, 17'h0,     2'b10};

    for (int v = 0; v < 12; v++) run_vec(vecs[v]);

    // Write aborted after 5 data bits: no strobe, next command decodes.
    cs_low();
    xfer_byte(8'h02, rx, oe);
    xfer_byte(8'h00, rx, oe);
    xfer_byte(8'h02, rx, oe);
    xfer_byte(8'h00, rx, oe);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, mi, oe);
    cs_high();
    chk("abort_oe", 32'(spi_miso_oe), 32'h0);
    cs_low();
    xfer_byte(8'h05, rx, oe);
    xfer_byte(8'h00, rx, oe);
    chk("abort_next_rdmr", 32'(rx), 32'h80);
    chk("abort_next_oe", 32'(oe), 32'h1);
    cs_high();

    // HOLD in the middle of a read byte.
    exp_re_q.push_back(17'h00040);
    exp_re_q.push_back(17'h00041);
    mem[17'h00040] = 8'h96;
    cs_low();
    xfer_byte(8'h03, rx, oe);
    xfer_byte(8'h00, rx, oe);
    xfer_byte(8'h00, rx, oe);
    xfer_byte(8'h40, rx, oe);
    for (int i = 7; i >= 4; i--) begin spi_bit(1'b0, mi, oe); rx[i] = mi; end
    spi_hold_n = 1'b0;
    wait_clks(SYNC + 4);
`ifdef SPI_HOLD_EN
    chk("hold_oe_low", 32'(spi_miso_oe), 32'h0);
    for (int p = 0; p < 4; p++) begin
      spi_sclk = 1'b1; wait_clks(HALF);
      spi_sclk = 1'b0; wait_clks(HALF);
    end
    chk("hold_oe_still_low", 32'(spi_miso_oe), 32'h0);
`else
    chk("hold_ignored_oe", 32'(spi_miso_oe), 32'h1);
`endif
    spi_hold_n = 1'b1;
    wait_clks(SYNC + 4);
    chk("hold_release_oe", 32'(spi_miso_oe), 32'h1);
    for (int i = 3; i >= 0; i--) begin spi_bit(1'b0, mi, oe); rx[i] = mi; end
    chk("hold_read_byte", 32'(rx), 32'h96);
    cs_high();

    // Reset in the middle of a write: no strobe, mode back to sequential.
    cs_low();
    xfer_byte(8'h02, rx, oe);
    xfer_byte(8'h00, rx, oe);
    xfer_byte(8'h03, rx, oe);
    xfer_byte(8'h00, rx, oe);
    for (int i = 0; i < 6; i++) spi_bit(1'b1, mi, oe);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 32'h0);
    chk("midrst_mode", 32'(mode), 32'h1);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    spi_cs_n = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(SYNC + 4);
    cs_low();
    xfer_byte(8'h05, rx, oe);
    xfer_byte(8'h00, rx, oe);
    chk("midrst_rdmr", 32'(rx), 32'h40);
    cs_high();

    chk("we_queue_empty", 32'(exp_we_q.size()), 32'h0);
    chk("re_queue_empty", 32'(exp_re_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
